// File: rtl/microwave_ctrl_pkg.sv
// Shared definitions for the microwave front-end controller.
// Holds the FSM state encoding, the BCD entry limits and the key
// acceptance helper used by the controller.
package microwave_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ENTRY  = 3'd1,
      S_COOK   = 3'd2,
      S_PAUSED = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [3:0] DIGIT_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX  = 4'd5;

   // A digit may be shifted in only if it is BCD and the digit it pushes
   // into the seconds-tens position stays a legal tens value.
   function automatic logic key_ok(input logic [3:0] digit, input logic [3:0] so);
      return (digit <= DIGIT_MAX) && (so <= TENS_MAX);
   endfunction

endpackage

// File: rtl/microwave_ctrl_tick.sv
// One-second strobe generator for the countdown timer.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   sclr - synchronous restart of the divider (a fresh cook)
//   run  - count this cycle; when low the divider value is held
//   tick - one-cycle strobe, registered, every TICK_DIV running cycles
module microwave_ctrl_tick #(
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic sclr,
   input  logic run,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TC_LOAD = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // Down-counter: reload value gives TICK_DIV running cycles between
   // strobes, with the strobe issued on the terminal-count edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= TC_LOAD;
         tick <= 1'b0;
      end else if (sclr) begin
         cnt  <= TC_LOAD;
         tick <= 1'b0;
      end else if (run) begin
         if (cnt == '0) begin
            cnt  <= TC_LOAD;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt - 1'b1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave front-end controller: keypad entry, timer load/strobe/clear
// sequencing, magnetron gating and end-of-cook indication.
// Ports:
//   clk, clear          - system clock, asynchronous active-high reset
//   key_valid/key_digit - keypad strobe and BCD digit
//   start, stop         - level requests sampled every cycle
//   door_closed         - 1 when the door is shut
//   tim_zero            - countdown timer reached 0:00
//   dig_min/st/so       - parallel load data for the timer
//   tim_load/enable     - one-cycle load pulse and countdown strobe
//   tim_clearn          - active-low timer clear
//   mag_on, done, state - magnetron drive, finished flag, debug state
//
// state  | meaning
// IDLE   | no time entered, waiting for keys
// ENTRY  | digits being entered, waiting for start
// COOK   | magnetron on, timer counting down
// PAUSED | cook suspended by stop or door, divider held
// DONE   | timer reached zero, waiting for acknowledge
module microwave_ctrl
   import microwave_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 10
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop,
   input  logic       door_closed,
   input  logic       tim_zero,
   output logic [3:0] dig_so,
   output logic [3:0] dig_st,
   output logic [3:0] dig_min,
   output logic       tim_load,
   output logic       tim_enable,
   output logic       tim_clearn,
   output logic       mag_on,
   output logic       done,
   output logic [2:0] state
);

   state_t cur;
   logic   key_acc;
   logic   time_set;
   logic   cook_go;
   logic   zero_seen;
   logic   cook_run;

   assign key_acc  = key_valid && key_ok(key_digit, dig_so);
   assign time_set = ({dig_min, dig_st, dig_so} != 12'd0);
   assign cook_go  = (cur == S_ENTRY) && !stop && door_closed && start && time_set;
   // The timer still holds its previous count while tim_load is high.
   assign zero_seen = tim_zero && !tim_load;
   assign cook_run  = (cur == S_COOK) && !zero_seen && !stop && door_closed;
   assign state     = cur;

   microwave_ctrl_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (clear),
      .sclr (cook_go),
      .run  (cook_run),
      .tick (tim_enable)
   );

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         cur        <= S_IDLE;
         dig_so     <= 4'd0;
         dig_st     <= 4'd0;
         dig_min    <= 4'd0;
         tim_load   <= 1'b0;
         tim_clearn <= 1'b0;
         mag_on     <= 1'b0;
         done       <= 1'b0;
      end else begin
         tim_load   <= 1'b0;
         tim_clearn <= 1'b1;
         case (cur)
            S_IDLE: begin
               if (!stop && key_acc) begin
                  dig_min <= dig_st;
                  dig_st  <= dig_so;
                  dig_so  <= key_digit;
                  cur     <= S_ENTRY;
               end
            end
            S_ENTRY: begin
               if (stop) begin
                  dig_min <= 4'd0;
                  dig_st  <= 4'd0;
                  dig_so  <= 4'd0;
                  cur     <= S_IDLE;
               end else if (cook_go) begin
                  tim_load <= 1'b1;
                  mag_on   <= 1'b1;
                  cur      <= S_COOK;
               end else if (key_acc) begin
                  dig_min <= dig_st;
                  dig_st  <= dig_so;
                  dig_so  <= key_digit;
               end
            end
            S_COOK: begin
               // Zero outranks stop: the cook is already over.
               if (zero_seen) begin
                  mag_on <= 1'b0;
                  done   <= 1'b1;
                  cur    <= S_DONE;
               end else if (stop || !door_closed) begin
                  mag_on <= 1'b0;
                  cur    <= S_PAUSED;
               end else begin
                  mag_on <= 1'b1;
               end
            end
            S_PAUSED: begin
               if (stop) begin
                  tim_clearn <= 1'b0;
                  dig_min    <= 4'd0;
                  dig_st     <= 4'd0;
                  dig_so     <= 4'd0;
                  cur        <= S_IDLE;
               end else if (door_closed && start) begin
                  mag_on <= 1'b1;
                  cur    <= S_COOK;
               end
            end
            S_DONE: begin
               if (stop || key_valid) begin
                  tim_clearn <= 1'b0;
                  dig_min    <= 4'd0;
                  dig_st     <= 4'd0;
                  dig_so     <= 4'd0;
                  done       <= 1'b0;
                  cur        <= S_IDLE;
               end
            end
            default: begin
               mag_on <= 1'b0;
               done   <= 1'b0;
               cur    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed bench for microwave_ctrl with a behavioural countdown timer.
module tb_microwave_ctrl;

   localparam int TICK_DIV = 10;
   localparam int ST_IDLE = 0, ST_ENTRY = 1, ST_COOK = 2, ST_PAUSED = 3, ST_DONE = 4;

   logic       clk = 1'b0;
   logic       clear, key_valid, start, stop, door_closed, tim_zero;
   logic [3:0] key_digit;
   logic [3:0] dig_so, dig_st, dig_min;
   logic       tim_load, tim_enable, tim_clearn, mag_on, done;
   logic [2:0] state;

   int n_checks = 0;
   int n_errors = 0;
   int tsec = 0;

   microwave_ctrl #(.TICK_DIV(TICK_DIV)) dut (
      .clk         (clk),
      .clear       (clear),
      .key_valid   (key_valid),
      .key_digit   (key_digit),
      .start       (start),
      .stop        (stop),
      .door_closed (door_closed),
      .tim_zero    (tim_zero),
      .dig_so      (dig_so),
      .dig_st      (dig_st),
      .dig_min     (dig_min),
      .tim_load    (tim_load),
      .tim_enable  (tim_enable),
      .tim_clearn  (tim_clearn),
      .mag_on      (mag_on),
      .done        (done),
      .state       (state)
   );

   always #5 clk = ~clk;

   // Countdown timer model: loads seconds from the digits, decrements on strobe.
   always @(posedge clk) begin
      if (tim_load)
         tsec <= int'(dig_min) * 60 + int'(dig_st) * 10 + int'(dig_so);
      else if (tim_enable && tsec > 0)
         tsec <= tsec - 1;
   end
   assign tim_zero = (tsec == 0);

   task automatic check(input string tag, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input int d);
      key_valid = 1'b1;
      key_digit = 4'(d);
      step();
      key_valid = 1'b0;
   endtask

   task automatic press_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      int ns, s1, s2, loads, done_cyc, pause_strobes, first_after, after_cnt;

      clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
      start = 1'b0; stop = 1'b0; door_closed = 1'b1;
      step(); step();
      check("rst_state", int'(state), ST_IDLE);
      check("rst_digits", int'({dig_min, dig_st, dig_so}), 0);
      check("rst_clearn", int'(tim_clearn), 0);
      check("rst_mag", int'(mag_on), 0);
      check("rst_done", int'(done), 0);
      clear = 1'b0;
      #2;
      check("rel_clearn_hold", int'(tim_clearn), 0);
      step();
      check("rel_clearn_edge", int'(tim_clearn), 1);

      // Key entry: 1,2,3 -> 1:23
      key(1); key(2); key(3);
      check("k123_min", int'(dig_min), 1);
      check("k123_st", int'(dig_st), 2);
      check("k123_so", int'(dig_so), 3);
      check("k123_state", int'(state), ST_ENTRY);
      press_stop();
      check("entry_stop_state", int'(state), ST_IDLE);
      check("entry_stop_dig", int'({dig_min, dig_st, dig_so}), 0);

      key(12);
      check("k12_state", int'(state), ST_IDLE);
      check("k12_so", int'(dig_so), 0);
      key(7); key(8);
      check("k78_so", int'(dig_so), 7);
      check("k78_st", int'(dig_st), 0);
      check("k78_state", int'(state), ST_ENTRY);

      // Start with door open is ignored
      door_closed = 1'b0; start = 1'b1;
      step();
      start = 1'b0; door_closed = 1'b1;
      check("door_start_load", int'(tim_load), 0);
      check("door_start_state", int'(state), ST_ENTRY);
      press_stop();

      // Start with 0:00 is ignored
      key(0);
      check("k0_state", int'(state), ST_ENTRY);
      start = 1'b1;
      step();
      start = 1'b0;
      check("zero_start_load", int'(tim_load), 0);
      check("zero_start_state", int'(state), ST_ENTRY);

      // Cook 0:02
      key(2);
      check("k2_so", int'(dig_so), 2);
      start = 1'b1;
      step();
      start = 1'b0;
      check("cook_load", int'(tim_load), 1);
      check("cook_state", int'(state), ST_COOK);
      check("cook_mag", int'(mag_on), 1);
      ns = 0; s1 = -1; s2 = -1; loads = 1; done_cyc = -1;
      for (int k = 2; k <= 40; k++) begin
         step();
         if (tim_enable) begin
            ns++;
            if (ns == 1) s1 = k;
            if (ns == 2) s2 = k;
         end
         if (tim_load) loads++;
         if (done && done_cyc < 0) done_cyc = k;
      end
      check("cook_strobes", ns, 2);
      check("cook_strobe1", s1, 11);
      check("cook_strobe2", s2, 21);
      check("cook_loads", loads, 1);
      check("cook_done_cyc", done_cyc, 23);
      check("cook_done_mag", int'(mag_on), 0);
      check("cook_done_state", int'(state), ST_DONE);

      // Key in DONE acknowledges without being captured
      key(3);
      check("ack_state", int'(state), ST_IDLE);
      check("ack_clearn", int'(tim_clearn), 0);
      check("ack_done", int'(done), 0);
      check("ack_so", int'(dig_so), 0);
      step();
      check("ack_clearn_back", int'(tim_clearn), 1);

      // Cook 0:03 with a door-open pause
      key(3);
      start = 1'b1;
      step();
      start = 1'b0;
      ns = 0; s1 = -1; s2 = -1;
      for (int k = 2; k <= 24; k++) begin
         step();
         if (tim_enable) begin
            ns++;
            if (ns == 1) s1 = k;
            if (ns == 2) s2 = k;
         end
      end
      check("p_strobe1", s1, 11);
      check("p_strobe2", s2, 21);
      door_closed = 1'b0;
      step();
      check("p_state", int'(state), ST_PAUSED);
      check("p_mag", int'(mag_on), 0);
      check("p_enable", int'(tim_enable), 0);
      pause_strobes = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (tim_enable) pause_strobes++;
      end
      check("p_no_strobes", pause_strobes, 0);
      check("p_state_hold", int'(state), ST_PAUSED);
      door_closed = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      check("resume_state", int'(state), ST_COOK);
      check("resume_mag", int'(mag_on), 1);
      check("resume_no_load", int'(tim_load), 0);
      first_after = -1; after_cnt = 0;
      for (int j = 1; j <= 60; j++) begin
         step();
         if (tim_enable) begin
            after_cnt++;
            if (first_after < 0) first_after = j;
         end
      end
      check("resume_first", first_after, TICK_DIV - 3);
      check("total_strobes", ns + pause_strobes + after_cnt, 3);
      check("resume_done", int'(state), ST_DONE);

      // Stop in PAUSED
      press_stop();
      check("done_stop_state", int'(state), ST_IDLE);
      key(5);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      stop = 1'b1;
      step();
      check("stop_cook_state", int'(state), ST_PAUSED);
      check("stop_cook_mag", int'(mag_on), 0);
      step();
      stop = 1'b0;
      check("stop_pause_state", int'(state), ST_IDLE);
      check("stop_pause_clearn", int'(tim_clearn), 0);
      check("stop_pause_so", int'(dig_so), 0);
      step();
      check("stop_pause_clearn_back", int'(tim_clearn), 1);

      // Asynchronous clear mid-cook
      key(4);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      check("pre_clr_mag", int'(mag_on), 1);
      #1 clear = 1'b1;
      #1;
      check("aclr_mag", int'(mag_on), 0);
      check("aclr_clearn", int'(tim_clearn), 0);
      check("aclr_state", int'(state), ST_IDLE);
      #2 clear = 1'b0;
      #1;
      check("aclr_rel_clearn", int'(tim_clearn), 0);
      step();
      check("aclr_edge_clearn", int'(tim_clearn), 1);
      check("aclr_edge_state", int'(state), ST_IDLE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
